uart_imem_loader: RTL and testbench



---
 rtl/uart_imem_loader_pkg.sv | 13 +
 rtl/uart_imem_loader_if.sv | 24 ++
 rtl/uart_imem_loader_assembler.sv | 30 +++
 rtl/uart_imem_loader.sv | 114 +++++++++++
 tb/tb_uart_imem_loader.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/uart_imem_loader_pkg.sv
// uart_imem_loader_pkg: shared state encoding, frame constants and address helper for the image loader
package uart_imem_loader_pkg;

    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, RUN} state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         CNT_W         = 16;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [CNT_W-1:0] idx);
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/uart_imem_loader_if.sv
// uart_imem_loader_if: UART byte input, instruction-memory write port and core control of the loader
interface uart_imem_loader_if #(parameter int XLEN = 32);

    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            imem_we;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_wdata;
    logic            cpu_hold;
    logic            load_done;
    logic            load_err;
    logic [15:0]     words_loaded;

    modport master (
        input  rx_data, rx_valid,
        output imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_loaded
    );

    modport slave (
        output rx_data, rx_valid,
        input  imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_loaded
    );

endinterface

// File: rtl/uart_imem_loader_assembler.sv
// loader_word_assembler: packs little-endian bytes into 32-bit words, flagging the word on its 4th byte
module loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] lanes;

    // The top byte is never stored: the word is presented combinationally as it arrives.
    assign word_valid = byte_valid && byte_idx == 2'd3;
    assign word       = {byte_data, lanes};

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            byte_idx <= '0;
            lanes    <= '0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx != 2'd3)
                lanes[8*byte_idx +: 8] <= byte_data;
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: loads a framed UART program image into instruction memory while holding the core in reset
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int          XLEN           = 32,
    parameter int          MEM_WORDS      = 256,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          TO_W           = 20
) (
    input logic                 clk,
    input logic                 reset,
    uart_imem_loader_if.master  bus
);

    state_t             state, state_nx;
    logic [TO_W-1:0]    to_cnt;
    logic [CNT_W-1:0]   n;
    logic [CNT_W-1:0]   word_idx;
    logic               last_q;
    logic               imem_we;
    logic [XLEN-1:0]    imem_addr;
    logic [XLEN-1:0]    imem_wdata;
    logic               load_err;
    logic [15:0]        words_loaded;
    logic               word_valid;
    logic [31:0]        word;
    logic               active, sync, timeout, frame_start, consume, last, in_range;

    assign active      = state == CNT_LO || state == CNT_HI || state == DATA;
    assign sync        = bus.rx_valid && bus.rx_data == SYNC_BYTE;
    assign timeout     = active && !last_q && !bus.rx_valid && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
    assign frame_start = sync && (state == IDLE || state == RUN);
    // Once the final word is captured, trailing bytes are ignored until RUN.
    assign consume     = bus.rx_valid && state == DATA && !last_q;
    assign last        = word_idx == n - 16'd1;
    assign in_range    = int'(word_idx) < MEM_WORDS;

    loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (state != DATA),
        .byte_valid (consume),
        .byte_data  (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = sync ? CNT_LO : IDLE;
            CNT_LO:  state_nx = timeout ? IDLE : bus.rx_valid ? CNT_HI : CNT_LO;
            CNT_HI:  state_nx = timeout ? IDLE : !bus.rx_valid ? CNT_HI :
                                ({bus.rx_data, n[7:0]} == 16'd0) ? RUN : DATA;
            // RUN is entered one cycle after the last write pulse is issued.
            DATA:    state_nx = last_q ? RUN : timeout ? IDLE : DATA;
            RUN:     state_nx = sync ? CNT_LO : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            to_cnt       <= '0;
            n            <= '0;
            word_idx     <= '0;
            last_q       <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= '0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            state   <= state_nx;
            to_cnt  <= (active && !bus.rx_valid && !timeout) ? to_cnt + 1'b1 : '0;
            imem_we <= word_valid && in_range;
            if (state == CNT_LO && bus.rx_valid)
                n[7:0] <= bus.rx_data;
            if (state == CNT_HI && bus.rx_valid)
                n[15:8] <= bus.rx_data;
            if (word_valid) begin
                word_idx <= word_idx + 1'b1;
                last_q   <= last;
                if (in_range) begin
                    imem_addr    <= word_addr(BASE_ADDR, word_idx);
                    imem_wdata   <= word;
                    words_loaded <= words_loaded + 1'b1;
                end else begin
                    load_err <= 1'b1;
                end
            end
            if (timeout)
                load_err <= 1'b1;
            if (frame_start) begin
                load_err     <= 1'b0;
                words_loaded <= '0;
                word_idx     <= '0;
                last_q       <= 1'b0;
            end
        end
    end

    assign bus.imem_we      = imem_we;
    assign bus.imem_addr    = imem_addr;
    assign bus.imem_wdata   = imem_wdata;
    assign bus.cpu_hold     = state != RUN;
    assign bus.load_done    = state == RUN;
    assign bus.load_err     = load_err;
    assign bus.words_loaded = words_loaded;

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: randomized frame stimulus with a write scoreboard and core-release timing checks
module tb_uart_imem_loader;

    localparam int          MEM_WORDS = 4;
    localparam int          TOUT      = 40;
    localparam logic [31:0] BASE      = 32'h0000_0000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          n_chk = 0;
    int          n_fail = 0;
    wr_t         q[$];
    logic [31:0] frame_w [8];

    uart_imem_loader_if #(.XLEN(32)) bus ();

    uart_imem_loader #(
        .XLEN(32), .MEM_WORDS(MEM_WORDS), .SYNC_BYTE(8'hA5), .BASE_ADDR(BASE),
        .TIMEOUT_CYCLES(TOUT), .TO_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && bus.imem_we) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", bus.imem_addr, e.a);
                chk("wr_data", bus.imem_wdata, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_frame(input int n, input int maxgap, input bit reload);
        logic [15:0] nn;
        logic [31:0] w;
        int          exp_words;
        nn = n[15:0];
        exp_words = (n < MEM_WORDS) ? n : MEM_WORDS;
        for (int i = 0; i < exp_words; i++)
            q.push_back('{BASE + 32'(4 * i), frame_w[i]});
        send_byte(8'hA5, reload ? 0 : $urandom_range(maxgap, 0));
        if (reload) begin
            chk("reload_hold", bus.cpu_hold, 1);
            chk("reload_done", bus.load_done, 0);
        end
        send_byte(nn[7:0], $urandom_range(maxgap, 0));
        send_byte(nn[15:8], n == 0 ? 0 : $urandom_range(maxgap, 0));
        for (int i = 0; i < n; i++) begin
            w = frame_w[i];
            for (int b = 0; b < 4; b++)
                send_byte(w[8*b +: 8], (i == n - 1 && b == 3) ? 0 : $urandom_range(maxgap, 0));
        end
        if (n > 0) begin
            chk("we_latency", {31'b0, bus.imem_we}, {31'b0, n <= MEM_WORDS});
            chk("hold_before_release", bus.cpu_hold, 1);
            @(negedge clk);
        end
        chk("hold_released", bus.cpu_hold, 0);
        chk("load_done", bus.load_done, 1);
        chk("load_err", bus.load_err, {31'b0, n > MEM_WORDS});
        chk("words_loaded", bus.words_loaded, exp_words);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we", bus.imem_we, 0);
        chk("rst_addr", bus.imem_addr, BASE);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_hold", bus.cpu_hold, 1);
        chk("rst_done", bus.load_done, 0);
        chk("rst_err", bus.load_err, 0);
        chk("rst_words", bus.words_loaded, 0);
        reset = 1'b0;
        @(negedge clk);

        frame_w[0] = 32'h00A00513;
        frame_w[1] = 32'h00100593;
        run_frame(2, 2, 0);

        send_byte(8'h00, 1);
        send_byte(8'hFF, 0);
        send_byte(8'h3C, 2);
        chk("garbage_run", bus.load_done, 1);
        frame_w[0] = 32'hDEADBEEF;
        run_frame(1, 0, 0);

        run_frame(0, 1, 0);

        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (TOUT - 1) @(negedge clk);
        chk("to_err_early", bus.load_err, 0);
        chk("to_hold_early", bus.cpu_hold, 1);
        @(negedge clk);
        chk("to_err", bus.load_err, 1);
        chk("to_hold", bus.cpu_hold, 1);
        chk("to_done", bus.load_done, 0);
        send_byte(8'h5A, 2);
        chk("to_idle_ignore", bus.load_err, 1);
        frame_w[0] = 32'h12345678;
        run_frame(1, 1, 0);

        for (int i = 0; i < 5; i++) frame_w[i] = $urandom;
        run_frame(5, 1, 0);

        frame_w[0] = 32'hCAFEF00D;
        run_frame(1, 1, 1);

        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", bus.imem_we, 0);
        chk("mid_rst_addr", bus.imem_addr, BASE);
        chk("mid_rst_wdata", bus.imem_wdata, 0);
        chk("mid_rst_hold", bus.cpu_hold, 1);
        chk("mid_rst_done", bus.load_done, 0);
        chk("mid_rst_err", bus.load_err, 0);
        chk("mid_rst_words", bus.words_loaded, 0);
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'h3C, 1);

        for (int f = 0; f < 10; f++) begin
            int n;
            n = $urandom_range(6, 0);
            for (int i = 0; i < 8; i++) frame_w[i] = $urandom;
            run_frame(n, 3, f[0]);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
